// File: rtl/instr_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch front end: opcode field, reset PC, FSM states.
// The opcode slice macro is shared by every stage that decodes instruction words.
`ifndef IFU_OPCODE_SLICE
`define IFU_OPCODE_SLICE(word, w) word[(w)-1 -: instr_fetch_unit_pkg::OPCODE_W]
`endif

package instr_fetch_unit_pkg;

    localparam int unsigned OPCODE_W         = 10;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_STALL,
        ST_HALTED
    } ifu_state_e;

    function automatic logic is_jump_opcode(input logic [OPCODE_W-1:0] opcode);
        return opcode[OPCODE_W-1];
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// ifu_fifo: synchronous in-order FIFO with flush; push and pop in one cycle are both honoured
// even when full, so the head is always the oldest live entry.
module ifu_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && ((count != FULL_COUNT) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited imem requests, in-order buffering,
// jump redirect with stale-response dropping. IFU_PERF_COUNT_EN adds perf_fetched/perf_dropped.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        INSTR_W    = 32,
    parameter int unsigned        ADDR_W     = 16,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ADDR_W-1:0]    imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INSTR_W-1:0]   imem_rsp_data,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [INSTR_W-1:0]   id_instr,
    output logic [ADDR_W-1:0]    id_pc,
    output logic [OPCODE_W-1:0]  id_opcode,
    input  logic                 jump_valid,
    input  logic [ADDR_W-1:0]    jump_target,
    input  logic                 halt_req,
    output logic                 halted
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_dropped
`endif
);
    localparam int unsigned    CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

    ifu_state_e                state;
    ifu_state_e                state_nxt;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         rsp_pc;
    logic [CNT_W-1:0]          in_flight;
    logic [CNT_W-1:0]          in_flight_nxt;
    logic [CNT_W-1:0]          drop_cnt;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_empty;
    logic [ADDR_W+INSTR_W-1:0] fifo_head;
    logic                      credit_ok;
    logic                      req_fire;
    logic                      rsp_drop;
    logic                      fifo_push;
    logic                      fifo_pop;

    assign credit_ok     = ({1'b0, in_flight} + {1'b0, fifo_count}) < CREDIT_LIMIT;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_drop      = imem_rsp_valid && ((drop_cnt != '0) || jump_valid);
    assign fifo_push     = imem_rsp_valid && !rsp_drop;
    assign fifo_pop      = id_valid && id_ready && !jump_valid;
    assign in_flight_nxt = in_flight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    assign imem_req_addr = pc;

    ifu_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_valid),
        .push      (fifo_push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign id_valid           = !fifo_empty;
    assign {id_pc, id_instr}  = fifo_head;
    assign id_opcode          = `IFU_OPCODE_SLICE(id_instr, INSTR_W);

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        halted         = 1'b0;
        unique case (state)
            ST_FETCH:  if (!credit_ok) state_nxt = ST_STALL;
            ST_STALL:  if (credit_ok) state_nxt = ST_FETCH;
            ST_HALTED: state_nxt = ST_FETCH;
            default:   state_nxt = ST_FETCH;
        endcase
        if (halt_req) begin
            state_nxt = ST_HALTED;
        end
        imem_req_valid = !rst && !halt_req && (state != ST_HALTED) && credit_ok;
        halted         = (state == ST_HALTED) && (in_flight == '0);
    end

    // Responses return in order and every live one follows the last redirect sequentially,
    // so the PC of the next kept word is a single counter rather than a per-request queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            rsp_pc    <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            in_flight <= in_flight_nxt;
            if (jump_valid) begin
                pc       <= jump_target;
                rsp_pc   <= jump_target;
                drop_cnt <= in_flight_nxt;
            end else begin
                if (req_fire) begin
                    pc <= pc + ADDR_W'(1);
                end
                if (fifo_push) begin
                    rsp_pc <= rsp_pc + ADDR_W'(1);
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef IFU_PERF_COUNT_EN
    logic [CNT_W:0] drop_inc;

    assign drop_inc = (jump_valid ? {1'b0, fifo_count} : '0) + (CNT_W+1)'(rsp_drop);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= sat_add32(perf_fetched, 32'(fifo_push));
            perf_dropped <= sat_add32(perf_dropped, 32'(drop_inc));
        end
    end
`endif

endmodule
